tdm_demux8: RTL and testbench
=============================

// Module: tdm_demux8
// PURPOSE
// - Receive end of an 8-slot time-division serial line; the transmit end is an 8:1 selector that scans D0..D7.
// - Each cycle one slot bit arrives on din; a slot counter routes it to the matching output bit, demux-style.
// - A full frame is transferred to D in one step, with a one-cycle valid pulse.
// - Also drives slot and state indicators for the lab board LEDs.
// PARAMETERS
// - SLOTS  8              Slots per frame; D width. Must be a power of 2, >= 2.
// - SEL_W  $clog2(SLOTS)  Slot counter width. Derived; do not override.
// PORTS
// - clk        in   1      Single clock; all state changes on its rising edge.
// - rst        in   1      Synchronous, active-high reset.
// - G          in   1      Strobe, active-low as on the selector. 1 = freeze all state; no capture.
// - sync       in   1      Frame marker; 1 while slot 0 is on din.
// - din        in   1      Serial slot bit; slot k carries frame bit k.
// - D          out  SLOTS  Last complete frame; D[k] = slot k bit.
// - valid      out  1      One-cycle pulse: D has just been updated.
// - frame_err  out  1      One-cycle pulse: sync protocol violation.
// - sel_show   out  SEL_W  Current slot counter, for LEDs.
// - lock_show  out  1      1 when state = RECV.
// BEHAVIOUR
// - Reset values (rst=1 at an edge): state HUNT, cnt 0, shadow buffer 0, D 0, valid 0, frame_err 0.
//   - rst has priority over every other input, including G.
// - States: HUNT (waiting for sync) and RECV (frame in progress).
// - G=1: state, cnt, buffer and D hold; valid=0; frame_err=0. sync and din are ignored.
// - The rules below apply only when G=0.
// - HUNT:
//   - sync=1: buf[0] <= din; cnt <= 1; go to RECV.
//   - sync=0: stay in HUNT; cnt stays 0.
// - RECV, cnt = 0:
//   - sync=1: buf[0] <= din; cnt <= 1.
//   - sync=0 (missing marker): frame_err=1; clear buf; go to HUNT.
// - RECV, 0 < cnt < SLOTS-1:
//   - sync=0: buf[cnt] <= din; cnt <= cnt+1.
// - RECV, cnt = SLOTS-1, sync=0:
//   - D <= {din, buf[SLOTS-2:0]} on this edge; valid=1 for the next cycle only.
//   - cnt wraps to 0; stay in RECV.
// - RECV, cnt != 0, sync=1 (early marker):
//   - frame_err=1; discard the partial frame; D unchanged.
//   - Treat this cycle as slot 0: buf <= {0..., din}; cnt <= 1.
// - Latency: D and valid are visible in the cycle after slot SLOTS-1 is presented on din.
// - Back-to-back frames: valid pulses exactly SLOTS enabled cycles apart.
// - D holds its value until the next complete frame. Errors and G never clear D; only rst clears D.
// - valid and frame_err are never both 1 in the same cycle.
// - sel_show = cnt; lock_show = (state == RECV). Both are registered, with no combinational input-to-output path.
// TESTING
// - T1 reset: rst=1 for 2 cycles -> D=8'h00, valid=0, frame_err=0, sel_show=0, lock_show=0.
// - T2 single frame 8'hA5: sync=1 with slot 0, then slots 1..7 -> D=8'hA5 and one valid pulse after the 8th edge.
// - T3 back-to-back 8'h3C then 8'hFF, sync at each slot 0 -> D=3C then FF; valid pulses 8 cycles apart; no frame_err.
// - T4 G=1 for 3 cycles at slot 4 of frame 8'h5A -> sel_show holds 4; after resume D=8'h5A, with valid 11 cycles after slot 0.
// - T5 sync at slot 5, then a clean frame 8'h81 -> frame_err 1 cycle; D keeps its old value; next D=8'h81.
// - T5b sync=0 at slot 0 of a frame -> frame_err 1 cycle; lock_show=0 (HUNT).
// - T6 rst=1 at slot 3 mid-frame -> next cycle: HUNT, D=0, sel_show=0; a following frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/tdm_demux8.sv
// Receive end of an 8-slot TDM serial line.
// Rebuilds each frame from din and presents it on D.
module tdm_demux8 #(
    parameter int SLOTS = 8,
    parameter int SEL_W = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             G,
    input  logic             sync,
    input  logic             din,
    output logic [SLOTS-1:0] D,
    output logic             valid,
    output logic             frame_err,
    output logic [SEL_W-1:0] sel_show,
    output logic             lock_show
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(SLOTS - 1);
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

    state_t           state, state_n;
    logic [SEL_W-1:0] cnt, cnt_n;
    logic [SLOTS-1:0] shadow, shadow_n;
    logic [SLOTS-1:0] d_n;
    logic             valid_n, err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            cnt       <= '0;
            shadow    <= '0;
            D         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shadow    <= shadow_n;
            D         <= d_n;
            valid     <= valid_n;
            frame_err <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shadow_n = shadow;
        d_n      = D;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        if (!G) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        shadow_n[0] = din;
                        cnt_n       = ONE;
                        state_n     = RECV;
                    end
                end
                RECV: begin
                    if (cnt == '0) begin
                        if (sync) begin
                            shadow_n[0] = din;
                            cnt_n       = ONE;
                        end else begin
                            err_n    = 1'b1;
                            shadow_n = '0;
                            state_n  = HUNT;
                        end
                    end else if (sync) begin
                        // early marker restarts the frame at slot 0
                        err_n    = 1'b1;
                        shadow_n = SLOTS'(din);
                        cnt_n    = ONE;
                    end else if (cnt == LAST) begin
                        d_n     = {din, shadow[SLOTS-2:0]};
                        valid_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        shadow_n[cnt] = din;
                        cnt_n         = cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_show  = cnt;
        lock_show = (state == RECV);
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed frame tests plus random
// traffic against a slot-position reference model.
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       G = 1'b0;
    logic       sync = 1'b0;
    logic       din = 1'b0;
    logic [7:0] D;
    logic       valid, frame_err, lock_show;
    logic [2:0] sel_show;

    tdm_demux8 dut (
        .clk(clk), .rst(rst), .G(G), .sync(sync), .din(din),
        .D(D), .valid(valid), .frame_err(frame_err),
        .sel_show(sel_show), .lock_show(lock_show)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_v = -1;

    // reference model: hunting flag, next slot position, partial bits
    bit       m_hunt = 1;
    int       m_pos = 0;
    bit [7:0] m_sh = 0;
    bit [7:0] m_d = 0;
    bit       m_v = 0;
    bit       m_e = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit g, input bit s, input bit d);
        if (r) begin
            m_hunt = 1; m_pos = 0; m_sh = 0; m_d = 0; m_v = 0; m_e = 0;
        end else if (g) begin
            m_v = 0; m_e = 0;
        end else begin
            m_v = 0; m_e = 0;
            if (m_hunt) begin
                if (s) begin m_sh[0] = d; m_pos = 1; m_hunt = 0; end
            end else if (m_pos == 0) begin
                if (s) begin m_sh[0] = d; m_pos = 1; end
                else begin m_e = 1; m_sh = 0; m_hunt = 1; end
            end else if (s) begin
                m_e = 1; m_sh = 8'(d); m_pos = 1;
            end else begin
                m_sh[m_pos] = d;
                if (m_pos == 7) begin
                    m_d = m_sh; m_v = 1; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit g, input bit s, input bit d);
        @(negedge clk);
        rst = r; G = g; sync = s; din = d;
        @(posedge clk);
        model(r, g, s, d);
        cyc++;
        #1;
        chk("D", 32'(D), 32'(m_d));
        chk("valid", 32'(valid), 32'(m_v));
        chk("frame_err", 32'(frame_err), 32'(m_e));
        chk("sel_show", 32'(sel_show), 32'(m_pos));
        chk("lock_show", 32'(lock_show), 32'(!m_hunt));
        if (valid) last_v = cyc;
    endtask

    task automatic frame(input bit [7:0] v);
        for (int k = 0; k < 8; k++) step(0, 0, k == 0, v[k]);
    endtask

    initial begin
        int v1, s0;
        bit [7:0] f;
        bit rr, gg, ss;

        // T1 reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t1_D", 32'(D), 32'h00);
        chk("t1_lock", 32'(lock_show), 0);

        // T2 single frame
        frame(8'hA5);
        chk("t2_D", 32'(D), 32'hA5);
        chk("t2_valid", 32'(valid), 1);
        step(0, 0, 1, 0);
        chk("t2_vpulse", 32'(valid), 0);
        step(1, 0, 0, 0);

        // T3 back-to-back
        frame(8'h3C);
        chk("t3_D1", 32'(D), 32'h3C);
        v1 = last_v;
        frame(8'hFF);
        chk("t3_D2", 32'(D), 32'hFF);
        chk("t3_gap", 32'(last_v - v1), 8);

        // T4 G hold at slot 4
        f = 8'h5A;
        step(0, 0, 1, f[0]);
        s0 = cyc;
        for (int k = 1; k < 4; k++) step(0, 0, 0, f[k]);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1));
            chk("t4_hold_sel", 32'(sel_show), 4);
        end
        for (int k = 4; k < 8; k++) step(0, 0, 0, f[k]);
        chk("t4_D", 32'(D), 32'h5A);
        chk("t4_lat", 32'(last_v - s0 + 1), 11);

        // T5 early marker at slot 5
        f = 8'h81;
        for (int k = 0; k < 5; k++) step(0, 0, k == 0, k[0]);
        step(0, 0, 1, f[0]);
        chk("t5_err", 32'(frame_err), 1);
        chk("t5_Dkeep", 32'(D), 32'h5A);
        for (int k = 1; k < 8; k++) step(0, 0, 0, f[k]);
        chk("t5_D", 32'(D), 32'h81);

        // T5b missing marker
        step(0, 0, 0, 1);
        chk("t5b_err", 32'(frame_err), 1);
        chk("t5b_lock", 32'(lock_show), 0);

        // T6 reset mid-frame
        for (int k = 0; k < 3; k++) step(0, 0, k == 0, 1);
        step(1, 0, 0, 1);
        chk("t6_D", 32'(D), 32'h00);
        chk("t6_sel", 32'(sel_show), 0);
        frame(8'hC3);
        chk("t6_Dnew", 32'(D), 32'hC3);

        // random traffic, mostly protocol-correct
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            gg = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) < 9)
                ss = m_hunt ? 1'($urandom_range(0, 1)) : (m_pos == 0);
            else
                ss = 1'($urandom_range(0, 1));
            step(rr, gg, ss, 1'($urandom_range(0, 1)));
            n_cmp++;
            assert (!(valid && frame_err)) else begin
                n_err++;
                $error("FAIL excl: valid=%0b frame_err=%0b both set",
                       valid, frame_err);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
